// File: rtl/raster_scan_ctrl.sv
// raster_scan_ctrl: frame sequencer for the 3x3 low-pass filter pipeline.
// Accepts source pixel beats, tracks column/row over a WIDTH x HEIGHT frame,
// drives per-beat position flags and appends one flush row for draining.
// Optional feature: define RASTER_FLUSH_EN to include the trailing flush row;
// without it the last active beat goes straight to DONE.
//
// state  | meaning
// IDLE   | waiting for a start with legal dimensions
// ACTIVE | forwarding source beats, col/row track position in frame
// FLUSH  | issuing one synthetic bottom-padded row (row held at height)
// DONE   | one-cycle frame-complete pulse
module raster_scan_ctrl #(
  parameter int XB = 10,
  parameter int YB = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [XB-1:0] i_width,
  input  logic [YB-1:0] i_height,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic          i_out_ready,
  output logic          o_valid_data,
  output logic          o_col1,
  output logic          o_colN,
  output logic          o_row1,
  output logic          o_rowM,
  output logic          o_flush,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic          o_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [XB-1:0] COL_ONE = XB'(1);
  localparam logic [XB-1:0] DIM_MIN_W = XB'(2);
  localparam logic [YB-1:0] DIM_MIN_H = YB'(2);
  localparam logic [YB:0]   ROW_ONE = (YB+1)'(1);

  state_t        state_q, state_d;
  logic [XB-1:0] width_q, width_d;
  logic [YB-1:0] height_q, height_d;
  logic [XB-1:0] col_q, col_d;
  logic [YB:0]   row_q, row_d;
  logic          err_q, err_d;

  logic          beat;
  logic          in_flush;
  logic          col_last;
  logic          row_last;
  logic [YB:0]   row_last_val;

  // Row counter is one bit wider so it can hold `height` during the flush row.
  assign row_last_val = {1'b0, height_q} - ROW_ONE;
  assign col_last     = (col_q == (width_q - COL_ONE));
  assign row_last     = (row_q == row_last_val);

`ifdef RASTER_FLUSH_EN
  assign in_flush = (state_q == FLUSH);
`else
  assign in_flush = 1'b0;
`endif

  assign o_busy       = (state_q != IDLE);
  assign o_frame_done = (state_q == DONE);
  assign o_err        = err_q;

  // Next-state, counter update, handshake and position flags.
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    col_d        = col_q;
    row_d        = row_q;
    err_d        = 1'b0;
    o_in_ready   = 1'b0;
    o_valid_data = 1'b0;
    o_flush      = 1'b0;
    beat         = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if ((i_width >= DIM_MIN_W) && (i_height >= DIM_MIN_H)) begin
            width_d  = i_width;
            height_d = i_height;
            col_d    = '0;
            row_d    = '0;
            state_d  = ACTIVE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        o_in_ready   = i_out_ready;
        beat         = i_in_valid & i_out_ready;
        o_valid_data = beat;
        if (beat) begin
          if (col_last) begin
            col_d = '0;
            row_d = row_q + ROW_ONE;
            if (row_last) begin
`ifdef RASTER_FLUSH_EN
              state_d = FLUSH;
`else
              state_d = DONE;
`endif
            end
          end else begin
            col_d = col_q + COL_ONE;
          end
        end
      end
      FLUSH: begin
`ifdef RASTER_FLUSH_EN
        beat         = i_out_ready;
        o_valid_data = beat;
        o_flush      = 1'b1;
        if (beat) begin
          if (col_last) begin
            col_d   = '0;
            state_d = DONE;
          end else begin
            col_d = col_q + COL_ONE;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    o_col1 = o_valid_data & (col_q == '0);
    o_colN = o_valid_data & col_last;
    o_row1 = o_valid_data & (row_q == '0) & ~in_flush;
    o_rowM = o_valid_data & (row_last | in_flush);
  end

  // State, configuration and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      col_q    <= col_d;
      row_q    <= row_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Bench for raster_scan_ctrl: a frame-level model builds the list of expected
// beats (flags per pixel plus flush row) and checks the DUT cycle by cycle.
module tb_raster_scan_ctrl;
  localparam int XB = 10;
  localparam int YB = 10;
`ifdef RASTER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [XB-1:0] i_width;
  logic [YB-1:0] i_height;
  logic          i_in_valid;
  logic          o_in_ready;
  logic          i_out_ready;
  logic          o_valid_data;
  logic          o_col1, o_colN, o_row1, o_rowM, o_flush;
  logic          o_busy, o_frame_done, o_err;

  int n_cmp = 0;
  int n_bad = 0;

  // {col1, colN, row1, rowM, flush} per expected datapath beat
  logic [4:0] exp_q[$];

  raster_scan_ctrl #(.XB(XB), .YB(YB)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_width(i_width),
    .i_height(i_height), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_out_ready(i_out_ready), .o_valid_data(o_valid_data), .o_col1(o_col1),
    .o_colN(o_colN), .o_row1(o_row1), .o_rowM(o_rowM), .o_flush(o_flush),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_in_ready"}, 32'(o_in_ready), 0);
    chk({tag, "_valid"}, 32'(o_valid_data), 0);
    chk({tag, "_flags"}, 32'({o_col1, o_colN, o_row1, o_rowM, o_flush}), 0);
    chk({tag, "_done"}, 32'(o_frame_done), 0);
    chk({tag, "_err"}, 32'(o_err), 0);
  endtask

  // mode 0: valid/ready always 1; 1: ready toggles; 2: random valid/ready
  task automatic run_frame(input int w, input int h, input int mode,
                           input int abort_at, input int glitch_at);
    int beats = 0;
    int cyc = 0;
    int len = 0;
    int budget;
    bit started = 0;
    bit done_seen = 0;
    logic ev;
    logic fl;
    exp_q.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        exp_q.push_back({c == 0, c == w - 1, r == 0, r == h - 1, 1'b0});
    if (FLUSH_EN)
      for (int c = 0; c < w; c++)
        exp_q.push_back({c == 0, c == w - 1, 1'b0, 1'b1, 1'b1});
    budget = 8 * (w * h + w) + 20;

    @(negedge clk);
    i_start = 1'b1; i_width = w[XB-1:0]; i_height = h[YB-1:0];
    i_in_valid = 1'b0; i_out_ready = 1'b0;
    @(posedge clk); #1;
    chk("busy_after_start", 32'(o_busy), 1);

    while (!done_seen && cyc < budget) begin
      @(negedge clk);
      i_start = (glitch_at >= 0 && beats == glitch_at);
      if (i_start) i_width = XB'(w + 3);
      case (mode)
        0: begin i_in_valid = 1'b1; i_out_ready = 1'b1; end
        1: begin i_in_valid = 1'b1; i_out_ready = ~cyc[0]; end
        default: begin
          i_in_valid  = ($urandom_range(0, 3) != 0);
          i_out_ready = ($urandom_range(0, 3) != 0);
        end
      endcase
      cyc++;
      #1;
      ev = 1'b0;
      if (exp_q.size() == 0) begin
        chk("frame_done", 32'(o_frame_done), 1);
        chk("done_valid", 32'(o_valid_data), 0);
        chk("done_busy", 32'(o_busy), 1);
        if (started) len++;
        done_seen = 1;
      end else begin
        fl = exp_q[0][0];
        ev = fl ? i_out_ready : (i_in_valid & i_out_ready);
        chk("in_ready", 32'(o_in_ready), fl ? 0 : 32'(i_out_ready));
        chk("valid_data", 32'(o_valid_data), 32'(ev));
        chk("flags", 32'({o_col1, o_colN, o_row1, o_rowM, o_flush}),
            ev ? 32'(exp_q[0]) : 0);
        chk("early_done", 32'(o_frame_done), 0);
        chk("busy", 32'(o_busy), 1);
        chk("err_in_frame", 32'(o_err), 0);
        if (ev) started = 1;
        if (started) len++;
        if (abort_at >= 0 && beats == abort_at && ev) begin
          rst = 1'b1;
          @(posedge clk); #1;
          chk_idle_outputs("abort");
          @(negedge clk);
          rst = 1'b0; i_start = 1'b0;
          #1;
          chk_idle_outputs("abort_after");
          return;
        end
      end
      @(posedge clk);
      if (ev) begin
        void'(exp_q.pop_front());
        beats++;
      end
    end
    chk("frame_done_seen", 32'(done_seen), 1);
    if (mode == 0)
      chk("frame_len", len, w * h + (FLUSH_EN ? w : 0) + 1);
    @(negedge clk);
    i_start = 1'b0;
    #1;
    chk("idle_after_frame_busy", 32'(o_busy), 0);
    chk("idle_after_frame_done", 32'(o_frame_done), 0);
  endtask

  task automatic bad_start(input int w, input int h);
    @(negedge clk);
    i_start = 1'b1; i_width = w[XB-1:0]; i_height = h[YB-1:0];
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    #1;
    chk("bad_start_err", 32'(o_err), 1);
    chk("bad_start_busy", 32'(o_busy), 0);
    @(negedge clk); #1;
    chk("bad_start_err_single", 32'(o_err), 0);
    chk("bad_start_busy_after", 32'(o_busy), 0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_width = '0; i_height = '0;
    i_in_valid = 1'b1; i_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_frame(4, 3, 0, -1, -1);
    run_frame(4, 3, 1, -1, -1);
    bad_start(1, 5);
    bad_start(5, 1);
    bad_start(0, 0);
    run_frame(2, 2, 0, -1, -1);
    run_frame(4, 3, 0, -1, 5);
    run_frame(4, 3, 0, 6, -1);
    run_frame(4, 3, 0, -1, -1);

    // reset and start together: reset wins, no frame, no error
    @(negedge clk);
    rst = 1'b1; i_start = 1'b1; i_width = 10'd4; i_height = 10'd3;
    @(posedge clk); #1;
    chk_idle_outputs("rst_start");
    @(negedge clk);
    rst = 1'b0; i_start = 1'b0;
    #1;
    chk_idle_outputs("rst_start_after");

    for (int k = 0; k < 4; k++)
      run_frame($urandom_range(2, 6), $urandom_range(2, 5), 2, -1, -1);
    run_frame(3, 4, 1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
